bus_interface_unit: RTL
=======================

# bus_interface_unit

Parametrised bus interface unit for the t8086 core. It keeps an instruction prefetch queue of configurable depth filled from the byte-wide ROM port. It also serves byte and word data reads and writes from the execution side over the byte-wide RAM read and write ports. Fetch and data access run concurrently on their separate ports; a flush reloads the fetch pointer on jumps.

## Interface
- `QUEUE_DEPTH`, 6: prefetch queue depth in bytes, ≥ 2.
- `ADDR_W`, 16: width of ROM, RAM and IP addresses.
- `FETCH_GAP`, 1: minimum free queue slots, counting in-flight fetches, required to issue a fetch; range 1..QUEUE_DEPTH.
- `RESET_IP`, 0: fetch pointer value after reset.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserted at 0, async assert, synchronously released.
- `flush`  in  1  discard queue and in-flight fetch, load `flush_ip`.
- `flush_ip`  in  ADDR_W  new fetch pointer.
- `q_rd`  in  1  pop head byte.
- `q_data`  out  8  head byte (combinational).
- `q_valid`  out  1  queue non-empty.
- `q_count`  out  $clog2(QUEUE_DEPTH+1)  bytes held.
- `mem_req`  in  1  data access request.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_word`  in  1  1 = 16-bit little-endian, 0 = byte.
- `mem_addr`  in  ADDR_W  data address.
- `mem_wdata`  in  16  write data; byte writes use [7:0].
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  16  read data, valid only while `mem_ack`=1 on a read.
- `rom_en`  out  1 / `rom_addr`  out  ADDR_W / `rom_data`  in  8  ROM fetch port.
- `ram_rd_en`  out  1 / `ram_rd_addr`  out  ADDR_W / `ram_rd_data`  in  8  RAM read port.
- `ram_wr_en`  out  1 / `ram_wr_addr`  out  ADDR_W / `ram_wr_data`  out  8  RAM write port.

## Operation
- Memory model: ROM and RAM reads return data on the cycle after `*_en`. RAM writes commit at the edge ending the `ram_wr_en` cycle.
- Reset values:
  - `q_count`=0, `q_valid`=0, `mem_ack`=0.
  - All enables 0.
  - Addresses and `ram_wr_data` 0.
  - Fetch pointer `fp`=RESET_IP.
  - No fetch pending.
  - Data FSM in IDLE.
  - Reset mid-operation aborts silently with no ack.
- Prefetch:
  - Each cycle with `flush`=0, issue a fetch when `q_count + pending ≤ QUEUE_DEPTH − FETCH_GAP`. `pending` is 1 if a fetch was issued last cycle and not discarded.
  - Issuing drives `rom_en`=1 and `rom_addr`=`fp`, then sets `fp ← fp+1` mod 2^ADDR_W.
  - Returned byte is pushed into the tail of the circular queue on the next cycle.
  - Push and pop in the same cycle: `q_count` unchanged. `q_rd` while empty is ignored.
  - The queue never overflows by construction; verification asserts this.
- Flush has priority over push, pop and issue. In the flush cycle:
  - `q_count ← 0` and the pending fetch is marked discarded, so its byte is not pushed.
  - `fp ← flush_ip`.
  - `rom_en`=0.
- Data FSM states:
  - IDLE: on `mem_req`, latch `mem_we`, `mem_word`, `mem_addr`, `mem_wdata`.
    - Read goes to RD_LO, write goes to WR_LO.
    - `mem_req` is ignored outside IDLE.
  - RD_LO: `ram_rd_en`=1 at `addr`. Next state is RD_HI for a word, RD_END for a byte.
  - RD_HI: latch low byte from `ram_rd_data`; `ram_rd_en`=1 at `addr+1` mod 2^ADDR_W. Next state RD_END.
  - RD_END: `mem_ack`=1. `mem_rdata` = word ? {`ram_rd_data`, lo_reg} : {8'h00, `ram_rd_data`}. Next state IDLE.
  - WR_LO: `ram_wr_en`=1, `addr`, `wdata[7:0]`.
    - Byte: `mem_ack`=1, go to IDLE.
    - Word: go to WR_HI.
  - WR_HI: `ram_wr_en`=1, `addr+1` mod 2^ADDR_W, `wdata[15:8]`, `mem_ack`=1. Next state IDLE.
- A request held high through ack is accepted again in the following IDLE cycle; the requester drops `mem_req` in the ack cycle.

## Timing
- Request sampled in cycle 0. Ack arrives in:
  - byte read: cycle 2
  - word read: cycle 3
  - byte write: cycle 1
  - word write: cycle 2
- Back-to-back accesses: next request sampled in the cycle after ack.
- Fetch issued in cycle N makes its byte visible on `q_data`/`q_valid` in cycle N+2.
- Flush in cycle F:
  - first fetch at `flush_ip` in F+1
  - that byte visible in F+3
- Prefetch sustains 1 byte/cycle while the issue condition holds.

## Test plan
- Reset fill (DEPTH=6, GAP=1, RESET_IP=0, no pops) -> `rom_addr` 0..5 on cycles 1..6 after release, then `rom_en`=0; `q_count`=6; `q_data`=ROM[0].
- Steady stream: `q_rd` held high after first byte -> `q_data` sequence ROM[0],ROM[1],… one per cycle, no gaps or duplicates; `q_count` stable.
- Flush with fetch in flight (`flush_ip`=16'h0100 while addr 3 pending) -> ROM[3] never pushed; `q_count`=0 in F+1; `rom_addr`=16'h0100 in F+1; `q_data`=ROM[0x100] in F+3.
- Word read at 16'hFFFF (RAM[FFFF]=8'h34, RAM[0000]=8'h12) -> `ram_rd_addr` FFFF then 0000; `mem_ack` in cycle 3 with `mem_rdata`=16'h1234.
- Word write 16'hBEEF at 16'h0010 -> `ram_wr_en` cycles 1–2, bytes EF at 0010 and BE at 0011; ack cycle 2. Byte read of 0011 -> 16'h00BE at cycle 2.
- Reset asserted during WR_HI of a word write -> no ack; all enables 0 immediately; FSM IDLE; queue empty; fetch restarts at RESET_IP.

Source files
------------

// File: rtl/bus_interface_unit.sv
// bus_interface_unit
// Bus interface unit for the t8086 core. Two independent engines share the
// clock:
//   * an instruction prefetcher that streams bytes from the byte-wide ROM port
//     into a circular queue of QUEUE_DEPTH bytes (flush reloads the pointer);
//   * a data FSM that serves byte / little-endian word reads and writes from
//     the execution side over the byte-wide RAM read and write ports.
// Ports:
//   clk, rst (async active-low)       clock and reset
//   flush, flush_ip                   discard queue, reload fetch pointer
//   q_rd, q_data, q_valid, q_count    prefetch queue consumer side
//   mem_req/we/word/addr/wdata        data request; mem_ack/mem_rdata reply
//   rom_en/rom_addr/rom_data          ROM fetch port (1-cycle read latency)
//   ram_rd_en/ram_rd_addr/ram_rd_data RAM read port (1-cycle read latency)
//   ram_wr_en/ram_wr_addr/ram_wr_data RAM write port
module bus_interface_unit #(
    parameter int                QUEUE_DEPTH = 6,
    parameter int                ADDR_W      = 16,
    parameter int                FETCH_GAP   = 1,
    parameter logic [ADDR_W-1:0] RESET_IP    = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [ADDR_W-1:0]                    flush_ip,
    input  logic                                 q_rd,
    output logic [7:0]                           q_data,
    output logic                                 q_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]     q_count,
    input  logic                                 mem_req,
    input  logic                                 mem_we,
    input  logic                                 mem_word,
    input  logic [ADDR_W-1:0]                    mem_addr,
    input  logic [15:0]                          mem_wdata,
    output logic                                 mem_ack,
    output logic [15:0]                          mem_rdata,
    output logic                                 rom_en,
    output logic [ADDR_W-1:0]                    rom_addr,
    input  logic [7:0]                           rom_data,
    output logic                                 ram_rd_en,
    output logic [ADDR_W-1:0]                    ram_rd_addr,
    input  logic [7:0]                           ram_rd_data,
    output logic                                 ram_wr_en,
    output logic [ADDR_W-1:0]                    ram_wr_addr,
    output logic [7:0]                           ram_wr_data
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    // Highest occupancy (queued + in flight) at which another fetch may go out.
    localparam logic [CNT_W:0] ISSUE_LIMIT = (CNT_W+1)'(QUEUE_DEPTH - FETCH_GAP);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(QUEUE_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        RD_END = 3'd3,
        WR_LO  = 3'd4,
        WR_HI  = 3'd5
    } dstate_e;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- prefetch queue ----------------
    logic [7:0]        qmem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] fp_q, fp_d;
    logic              pend_q;   // a fetch issued last cycle whose byte arrives now
    logic              run_q;    // holds issue off until the first edge after reset release
    logic [CNT_W:0]    occ_s;
    logic              issue_s, push_s, pop_s;

    assign occ_s   = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
    assign issue_s = run_q && !flush && (occ_s <= ISSUE_LIMIT);
    // Flush discards the byte of the fetch that is in flight.
    assign push_s  = pend_q && !flush;
    assign pop_s   = q_rd && (count_q != '0) && !flush;

    // The fetch port is combinational so a flush suppresses issue in its own cycle.
    assign rom_en   = issue_s;
    assign rom_addr = issue_s ? fp_q : '0;
    assign q_data   = qmem_q[head_q];
    assign q_valid  = (count_q != '0);
    assign q_count  = count_q;

    // Next-state for queue pointers, occupancy and fetch pointer.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fp_d    = fp_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fp_d    = flush_ip;
        end else begin
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            if (push_s) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (issue_s) begin
                fp_d = fp_q + ADDR_W'(1);
            end else begin
                fp_d = fp_q;
            end
        end
    end

    // Prefetch state registers and queue storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fp_q    <= RESET_IP;
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                qmem_q[i] <= 8'h00;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fp_q    <= fp_d;
            pend_q  <= issue_s;
            run_q   <= 1'b1;
            if (push_s) begin
                qmem_q[tail_q] <= rom_data;
            end
        end
    end

    // ---------------- data access FSM ----------------
    dstate_e           state_q;
    logic              word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;
    logic              mem_ack_q, ram_rd_en_q, ram_wr_en_q;
    logic [ADDR_W-1:0] ram_rd_addr_q, ram_wr_addr_q;
    logic [7:0]        ram_wr_data_q;

    assign mem_ack     = mem_ack_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;

    // Read data arrives in the ack cycle itself, so the final byte is passed straight through.
    always_comb begin
        mem_rdata = 16'h0000;
        if (state_q == RD_END) begin
            mem_rdata = word_q ? {ram_rd_data, lo_q} : {8'h00, ram_rd_data};
        end else begin
            mem_rdata = 16'h0000;
        end
    end

    // Data FSM with registered port strobes, set up one state ahead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            word_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 16'h0000;
            lo_q          <= 8'h00;
            mem_ack_q     <= 1'b0;
            ram_rd_en_q   <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    ram_rd_en_q <= 1'b0;
                    ram_wr_en_q <= 1'b0;
                    mem_ack_q   <= 1'b0;
                    if (mem_req) begin
                        word_q  <= mem_word;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        if (mem_we) begin
                            state_q       <= WR_LO;
                            ram_wr_en_q   <= 1'b1;
                            ram_wr_addr_q <= mem_addr;
                            ram_wr_data_q <= mem_wdata[7:0];
                            mem_ack_q     <= !mem_word;   // byte write completes in WR_LO
                        end else begin
                            state_q       <= RD_LO;
                            ram_rd_en_q   <= 1'b1;
                            ram_rd_addr_q <= mem_addr;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_LO: begin
                    if (word_q) begin
                        state_q       <= RD_HI;
                        ram_rd_en_q   <= 1'b1;
                        ram_rd_addr_q <= addr_q + ADDR_W'(1);
                    end else begin
                        state_q     <= RD_END;
                        ram_rd_en_q <= 1'b0;
                        mem_ack_q   <= 1'b1;
                    end
                end
                RD_HI: begin
                    lo_q        <= ram_rd_data;
                    state_q     <= RD_END;
                    ram_rd_en_q <= 1'b0;
                    mem_ack_q   <= 1'b1;
                end
                RD_END: begin
                    state_q   <= IDLE;
                    mem_ack_q <= 1'b0;
                end
                WR_LO: begin
                    if (word_q) begin
                        state_q       <= WR_HI;
                        ram_wr_en_q   <= 1'b1;
                        ram_wr_addr_q <= addr_q + ADDR_W'(1);
                        ram_wr_data_q <= wdata_q[15:8];
                        mem_ack_q     <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        ram_wr_en_q <= 1'b0;
                        mem_ack_q   <= 1'b0;
                    end
                end
                WR_HI: begin
                    state_q     <= IDLE;
                    ram_wr_en_q <= 1'b0;
                    mem_ack_q   <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    ram_rd_en_q <= 1'b0;
                    ram_wr_en_q <= 1'b0;
                    mem_ack_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
